// File: rtl/round_sequencer.sv
// Multi-round, multi-stage step-unit sequencer with per-stage watchdog, abort and error state.
// Each round walks stage units 0..NUM_STAGES-1 over start/ready handshakes; the result is stored after the final round.
module round_sequencer #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned RND_W      = 5,
    parameter int unsigned STG_W      = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  clear_err,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  ready,
    output logic                  load_en,
    output logic                  store_en,
    output logic                  done,
    output logic                  err,
    output logic [RND_W-1:0]      round_idx,
    output logic [STG_W-1:0]      stage_idx
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RND_W-1:0] rnd_nxt;
    logic [STG_W-1:0] stg_nxt;
    logic [WD_W-1:0]  wdog;
    logic [WD_W-1:0]  wdog_nxt;
    logic             cur_ready;
    logic             wd_hit;

    assign cur_ready = stage_ready[stage_idx];
    assign wd_hit    = (TIMEOUT != 0) && (wdog == WD_LAST);

    // Next-state, index and watchdog logic; abort overrides everything in active states.
    always_comb begin
        state_nxt = state;
        rnd_nxt   = round_idx;
        stg_nxt   = stage_idx;
        wdog_nxt  = wdog;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                rnd_nxt   = '0;
                stg_nxt   = '0;
                wdog_nxt  = '0;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (wd_hit) begin
                    state_nxt = S_ERR;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                    if (!cur_ready) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Stage completion wins over a coincident watchdog expiry.
                if (cur_ready) begin
                    wdog_nxt = '0;
                    if (stage_idx != LAST_STG) begin
                        stg_nxt   = stage_idx + 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (round_idx != LAST_RND) begin
                        rnd_nxt   = round_idx + 1'b1;
                        stg_nxt   = '0;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_STORE;
                    end
                end else if (wd_hit) begin
                    state_nxt = S_ERR;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            S_STORE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (clear_err) begin
                    rnd_nxt   = '0;
                    stg_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort && (state == S_LOAD || state == S_ISSUE ||
                      state == S_WAIT || state == S_STORE)) begin
            rnd_nxt   = '0;
            stg_nxt   = '0;
            state_nxt = S_IDLE;
        end
    end

    // State register; outputs are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            round_idx   <= '0;
            stage_idx   <= '0;
            wdog        <= '0;
            ready       <= 1'b1;
            load_en     <= 1'b0;
            store_en    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            stage_start <= '0;
        end else begin
            state       <= state_nxt;
            round_idx   <= rnd_nxt;
            stage_idx   <= stg_nxt;
            wdog        <= wdog_nxt;
            ready       <= (state_nxt == S_IDLE);
            load_en     <= (state_nxt == S_LOAD);
            store_en    <= (state_nxt == S_STORE);
            done        <= (state_nxt == S_STORE);
            err         <= (state_nxt == S_ERR);
            stage_start <= (state_nxt == S_ISSUE) ? (NUM_STAGES'(1) << stg_nxt) : '0;
        end
    end

endmodule
